// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the protected 16-bit counter path.
// The upstream encoder and the downstream checker both use hamming74_parity.
package hamming_pkg;

  localparam int NIBBLES = 4;
  localparam int DATA_W  = 16;
  localparam int CHK_W   = 12;

  // Syndrome value that points at each data bit; 1, 2 and 4 point at check bits.
  localparam logic [2:0] SYN_D0 = 3'd3;
  localparam logic [2:0] SYN_D1 = 3'd5;
  localparam logic [2:0] SYN_D2 = 3'd6;
  localparam logic [2:0] SYN_D3 = 3'd7;

  function automatic logic [2:0] hamming74_parity(input logic [3:0] d);
    return {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

endpackage

// File: rtl/hamming74_dec.sv
// Combinational Hamming(7,4) decoder for one nibble: syndrome plus
// single-bit correction of the data bits.
module hamming74_dec
  import hamming_pkg::*;
(
  input  logic [3:0] data_i,
  input  logic [2:0] check_i,
  output logic [3:0] data_o,
  output logic [2:0] syndrome_o,
  output logic       err_o
);

  logic [2:0] syn;

  always_comb begin
    syn    = hamming74_parity(data_i) ^ check_i;
    data_o = data_i;
    case (syn)
      SYN_D0:  data_o[0] = ~data_i[0];
      SYN_D1:  data_o[1] = ~data_i[1];
      SYN_D2:  data_o[2] = ~data_i[2];
      SYN_D3:  data_o[3] = ~data_i[3];
      default: data_o = data_i;
    endcase
    syndrome_o = syn;
    err_o      = |syn;
  end

endmodule

// File: rtl/hamming_nibble_checker.sv
// Two-stage checker: per-nibble Hamming correction, error-event counting and
// a sequence check of the corrected counter value against its predecessor.
module hamming_nibble_checker
  import hamming_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter bit SEQ_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_check,
  input  logic              in_inc,
  input  logic              clr_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [NIBBLES-1:0] err_nibble,
  output logic              seq_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky
);

  logic [DATA_W-1:0]           dec_data;
  logic [NIBBLES-1:0][2:0]     dec_syn;
  logic [NIBBLES-1:0]          dec_err;

  for (genvar k = 0; k < NIBBLES; k++) begin : g_dec
    hamming74_dec u_dec (
      .data_i     (in_data[4*k +: 4]),
      .check_i    (in_check[3*k +: 3]),
      .data_o     (dec_data[4*k +: 4]),
      .syndrome_o (dec_syn[k]),
      .err_o      (dec_err[k])
    );
  end

  // Correction is applied before the stage-1 register; the any-error bit is
  // precomputed so stage 2 only has the counter compare on its path.
  logic                    s1_valid_q;
  logic [DATA_W-1:0]       s1_data_q;
  logic [NIBBLES-1:0][2:0] s1_syn_q;
  logic                    s1_inc_q;
  logic                    s1_any_q;

  logic                    out_valid_q;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [NIBBLES-1:0]      err_nibble_q, err_nibble_d;
  logic                    seq_err_q, seq_err_d;
  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
  logic                    err_sticky_q, err_sticky_d;
  logic [DATA_W-1:0]       prev_q, prev_d;
  logic                    prev_ok_q, prev_ok_d;
  logic [DATA_W-1:0]       seq_expect;

  assign seq_expect = prev_q + DATA_W'(s1_inc_q);

  always_comb begin
    out_data_d   = out_data_q;
    err_nibble_d = '0;
    seq_err_d    = 1'b0;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    prev_d       = prev_q;
    prev_ok_d    = prev_ok_q;
    if (s1_valid_q) begin
      out_data_d = s1_data_q;
      for (int k = 0; k < NIBBLES; k++) begin
        err_nibble_d[k] = |s1_syn_q[k];
      end
      seq_err_d = SEQ_CHECK && prev_ok_q && (s1_data_q != seq_expect);
      prev_d    = s1_data_q;
      prev_ok_d = 1'b1;
      if (s1_any_q && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (s1_any_q || seq_err_d) begin
        err_sticky_d = 1'b1;
      end
    end
    if (clr_err) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
      s1_inc_q     <= 1'b0;
      s1_any_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      err_nibble_q <= '0;
      seq_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
    end else begin
      s1_valid_q   <= in_valid;
      s1_data_q    <= dec_data;
      s1_syn_q     <= dec_syn;
      s1_inc_q     <= in_inc;
      s1_any_q     <= |dec_err;
      out_valid_q  <= s1_valid_q;
      out_data_q   <= out_data_d;
      err_nibble_q <= err_nibble_d;
      seq_err_q    <= seq_err_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
      prev_q       <= prev_d;
      prev_ok_q    <= prev_ok_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign err_nibble = err_nibble_q;
  assign seq_err    = seq_err_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_hamming_nibble_checker.sv
// Scoreboard bench for hamming_nibble_checker: the driver pushes expected
// beats from the true (uncorrupted) value, a negedge monitor pops and compares.
module tb_hamming_nibble_checker;

  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [11:0] in_check = '0;
  logic        in_inc = 1'b0;
  logic        clr_err = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  err_nibble;
  logic        seq_err;
  logic [CW-1:0] err_cnt;
  logic        err_sticky;

  hamming_nibble_checker #(.CNT_W(CW), .SEQ_CHECK(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_check   (in_check),
    .in_inc     (in_inc),
    .clr_err    (clr_err),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .err_nibble (err_nibble),
    .seq_err    (seq_err),
    .err_cnt    (err_cnt),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  err;
    logic        seq;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] mprev = '0;
  bit          mprev_ok = 1'b0;
  int          m_cnt = 0;
  bit          m_sticky = 1'b0;
  logic [15:0] m_last = '0;
  bit          rst_pend = 1'b1;
  bit          clr_pend = 1'b0;

  function automatic logic [11:0] enc(input logic [15:0] v);
    logic [11:0] c;
    logic [3:0]  d;
    c = '0;
    for (int k = 0; k < 4; k++) begin
      d = v[4*k +: 4];
      c[3*k]   = d[0] ^ d[1] ^ d[3];
      c[3*k+1] = d[0] ^ d[2] ^ d[3];
      c[3*k+2] = d[1] ^ d[2] ^ d[3];
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit v, input logic [15:0] d, input bit inc,
                     input logic [15:0] dflip, input logic [11:0] cflip, input bit clr);
    exp_t        e;
    logic [15:0] nx;
    @(posedge clk);
    #1;
    in_valid = v;
    in_inc   = inc;
    in_data  = d ^ dflip;
    in_check = enc(d) ^ cflip;
    clr_err  = clr;
    if (v) begin
      for (int k = 0; k < 4; k++) begin
        e.err[k] = (dflip[4*k +: 4] != 4'h0) || (cflip[3*k +: 3] != 3'h0);
      end
      nx       = mprev + 16'(inc);
      e.data   = d;
      e.seq    = mprev_ok && (d != nx);
      mprev    = d;
      mprev_ok = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    clr_err  = 1'b0;
    mprev_ok = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    have = 1'b0;
    if (rst_pend) begin
      sb.delete();
      m_cnt    = 0;
      m_sticky = 1'b0;
      m_last   = '0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err_nibble", err_nibble, 0);
      chk("rst_seq_err", seq_err, 0);
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 (no beat pending) at %0t", $time);
        end else begin
          e    = sb.pop_front();
          have = 1'b1;
        end
      end
      if (clr_pend) begin
        m_cnt    = 0;
        m_sticky = 1'b0;
      end else if (have) begin
        if (e.err != 4'h0 && m_cnt < CMAX) m_cnt++;
        if (e.err != 4'h0 || e.seq) m_sticky = 1'b1;
      end
      if (have) begin
        chk("out_data", out_data, e.data);
        chk("err_nibble", err_nibble, e.err);
        chk("seq_err", seq_err, e.seq);
        m_last = e.data;
      end else if (!out_valid) begin
        chk("bubble_err_nibble", err_nibble, 0);
        chk("bubble_seq_err", seq_err, 0);
        chk("bubble_out_data", out_data, m_last);
      end
    end
    chk("err_cnt", err_cnt, m_cnt);
    chk("err_sticky", err_sticky, m_sticky);
    rst_pend = reset;
    clr_pend = clr_err;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v, df;
    logic [11:0] cf;
    bit          inc;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(i), 1'b1, 16'h0, 12'h0, 1'b0);
    cyc(1'b1, 16'h0000, 1'b1, 16'h0008, 12'h000, 1'b0);
    cyc(1'b1, 16'h1234, 1'b1, 16'h0000, 12'h008, 1'b0);
    cyc(1'b1, 16'h1235, 1'b1, 16'h1001, 12'h000, 1'b0);
    idle(3);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b1);
    idle(2);

    do_reset(1);
    cyc(1'b1, 16'h0010, 1'b1, 16'h0, 12'h0, 1'b0);
    cyc(1'b1, 16'h0011, 1'b1, 16'h0, 12'h0, 1'b0);
    cyc(1'b1, 16'h0011, 1'b0, 16'h0, 12'h0, 1'b0);
    cyc(1'b1, 16'h0015, 1'b1, 16'h0, 12'h0, 1'b0);
    cyc(1'b1, 16'h0016, 1'b1, 16'h0, 12'h0, 1'b0);
    cyc(1'b1, 16'hFFFF, 1'b1, 16'h0, 12'h0, 1'b0);
    cyc(1'b1, 16'h0000, 1'b1, 16'h0, 12'h0, 1'b0);
    idle(3);

    cyc(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b1);
    idle(2);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0021 + 16'(i), 1'b1, 16'h0100, 12'h0, 1'b0);
    idle(3);
    cyc(1'b1, 16'h0026, 1'b1, 16'h0100, 12'h0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b1);
    idle(3);

    cyc(1'b1, 16'h0042, 1'b1, 16'h0020, 12'h0, 1'b0);
    do_reset(1);
    cyc(1'b1, 16'h0099, 1'b0, 16'h0, 12'h0, 1'b0);
    idle(3);

    for (int n = 0; n < 400; n++) begin
      inc = 1'($urandom_range(1));
      if (!mprev_ok || $urandom_range(9) == 0) v = 16'($urandom);
      else v = mprev + 16'(inc);
      df = '0;
      cf = '0;
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(5))
          0: df[4*k + $urandom_range(3)] = 1'b1;
          1: cf[3*k + $urandom_range(2)] = 1'b1;
          default: ;
        endcase
      end
      cyc(($urandom_range(3) != 0), v, inc, df, cf, ($urandom_range(19) == 0));
    end
    idle(4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
